// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the SimpleRISC pipeline. Accepts the EX/MA bundle,
// runs the ld/st data-memory transaction over a request/ready handshake of
// variable latency, stalls upstream while the request is outstanding, and
// presents a registered MA/RW bundle to writeback.
//
// Handshake semantics (both sides):
//   Upstream : a bundle transfers on a rising edge where in_valid=1 and
//              in_ready=1. Upstream holds its bundle while in_ready=0.
//              in_ready depends on the state register only.
//   Memory   : a request completes on a rising edge where mem_req=1 and
//              mem_ready=1. mem_ready is ignored while mem_req=0. mem_addr,
//              mem_we and mem_wdata are stable for the life of a request.
//   Writeback: out_valid is a one-cycle pulse; isWb is forced low whenever
//              out_valid is low, other bundle fields hold between pulses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      EX/MA bundle handshake
//   in_pc, in_aluResult,     PC, ALU result (effective address),
//   in_op2, in_inst          store data, instruction word
//   in_isLd, in_isSt,        decoded control flags
//   in_isCall, in_isWb
//   mem_req, mem_we,         data-memory request (we=1 store, 0 load)
//   mem_addr, mem_wdata
//   mem_ready, mem_rdata     memory completion and load data
//   out_valid                MA/RW bundle is new this cycle
//   pc, ldResult, aluResult, MA/RW bundle
//   inst, isLd, isCall, isWb
//   mem_err                  misaligned or timed-out access (with out_valid)
//   dbg_state                1 while a memory request is outstanding
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_op2,
    input  logic [31:0] in_inst,
    input  logic        in_isLd,
    input  logic        in_isSt,
    input  logic        in_isCall,
    input  logic        in_isWb,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        out_valid,
    output logic [31:0] pc,
    output logic [31:0] ldResult,
    output logic [31:0] aluResult,
    output logic [31:0] inst,
    output logic        isLd,
    output logic        isCall,
    output logic        isWb,
    output logic        mem_err,

    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_t;

    // Counter value on which an unanswered request is abandoned; the request
    // has then been presented for exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;

    // Holding registers for the instruction while its request is in flight.
    logic [31:0] hold_pc;
    logic [31:0] hold_alu;
    logic [31:0] hold_op2;
    logic [31:0] hold_inst;
    logic        hold_isLd;
    logic        hold_isCall;
    logic        hold_isWb;
    logic        hold_we;

    // Decode of the incoming bundle.
    logic        in_is_mem;
    logic        in_misaligned;
    logic        in_is_store;

    always_comb begin
        in_is_mem     = in_isLd | in_isSt;
        in_misaligned = in_is_mem & (in_aluResult[1:0] != 2'b00);
        // A bundle flagged as both load and store is treated as a load.
        in_is_store   = in_isSt & ~in_isLd;
    end

    assign in_ready  = (state == S_IDLE);
    assign dbg_state = (state == S_MEM);

    assign mem_addr  = hold_alu;
    assign mem_wdata = hold_op2;
    assign mem_we    = hold_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            mem_req     <= 1'b0;
            hold_pc     <= 32'd0;
            hold_alu    <= 32'd0;
            hold_op2    <= 32'd0;
            hold_inst   <= 32'd0;
            hold_isLd   <= 1'b0;
            hold_isCall <= 1'b0;
            hold_isWb   <= 1'b0;
            hold_we     <= 1'b0;
            out_valid   <= 1'b0;
            mem_err     <= 1'b0;
            pc          <= 32'd0;
            ldResult    <= 32'd0;
            aluResult   <= 32'd0;
            inst        <= 32'd0;
            isLd        <= 1'b0;
            isCall      <= 1'b0;
            isWb        <= 1'b0;
        end else begin
            // Pulse outputs default low; isWb is gated with out_valid so a
            // held bundle can never be committed twice.
            out_valid <= 1'b0;
            mem_err   <= 1'b0;
            isWb      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!in_is_mem) begin
                            // Plain ALU/branch instruction: pass straight
                            // through in a single cycle.
                            pc        <= in_pc;
                            aluResult <= in_aluResult;
                            inst      <= in_inst;
                            isLd      <= in_isLd;
                            isCall    <= in_isCall;
                            ldResult  <= 32'd0;
                            isWb      <= in_isWb;
                            out_valid <= 1'b1;
                        end else if (in_misaligned) begin
                            // Misaligned access: never reaches memory and
                            // must not write back.
                            pc        <= in_pc;
                            aluResult <= in_aluResult;
                            inst      <= in_inst;
                            isLd      <= in_isLd;
                            isCall    <= in_isCall;
                            ldResult  <= 32'd0;
                            isWb      <= 1'b0;
                            mem_err   <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            hold_pc     <= in_pc;
                            hold_alu    <= in_aluResult;
                            hold_op2    <= in_op2;
                            hold_inst   <= in_inst;
                            hold_isLd   <= in_isLd;
                            hold_isCall <= in_isCall;
                            hold_isWb   <= in_isWb;
                            hold_we     <= in_is_store;
                            wait_cnt    <= 8'd0;
                            mem_req     <= 1'b1;
                            state       <= S_MEM;
                        end
                    end
                end

                S_MEM: begin
                    // A completion on the final wait cycle still counts as a
                    // successful access; the timeout only fires without one.
                    if (mem_ready) begin
                        pc        <= hold_pc;
                        aluResult <= hold_alu;
                        inst      <= hold_inst;
                        isLd      <= hold_isLd;
                        isCall    <= hold_isCall;
                        ldResult  <= hold_we ? 32'd0 : mem_rdata;
                        isWb      <= hold_isWb;
                        out_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        pc        <= hold_pc;
                        aluResult <= hold_alu;
                        inst      <= hold_inst;
                        isLd      <= hold_isLd;
                        isCall    <= hold_isCall;
                        ldResult  <= 32'd0;
                        isWb      <= 1'b0;
                        mem_err   <= 1'b1;
                        out_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (TIMEOUT=4). Inputs are driven and
// outputs sampled on the falling edge. A behavioural model turns each
// instruction plus the memory's response latency into the expected number
// of request cycles and the expected MA/RW bundle.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;
    // Expected bundle: {pc, aluResult, inst, isLd, isCall, isWb, mem_err}
    localparam int W = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_aluResult, in_op2, in_inst;
    logic        in_isLd, in_isSt, in_isCall, in_isWb;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] pc, ldResult, aluResult, inst;
    logic        isLd, isCall, isWb, mem_err;
    logic        dbg_state;

    int          total = 0;
    int          bad   = 0;
    logic        ready_tied = 1'b0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_aluResult(in_aluResult), .in_op2(in_op2), .in_inst(in_inst),
        .in_isLd(in_isLd), .in_isSt(in_isSt), .in_isCall(in_isCall), .in_isWb(in_isWb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .pc(pc), .ldResult(ldResult), .aluResult(aluResult),
        .inst(inst), .isLd(isLd), .isCall(isCall), .isWb(isWb), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: memory answers on request cycle 'lat' (0 = never).
    task automatic model(input logic [31:0] p, input logic [31:0] a, input logic [31:0] i,
                         input logic ld, input logic st, input logic call, input logic wb,
                         input int lat, input logic [31:0] data,
                         output int reqs, output logic [31:0] ldres, output bit ld_chk);
        logic err, owb;
        if (!(ld || st)) begin
            reqs = 0; err = 1'b0; owb = wb; ld_chk = 1'b0; ldres = 32'd0;
        end else if (a % 4 != 0) begin
            reqs = 0; err = 1'b1; owb = 1'b0; ld_chk = 1'b1; ldres = 32'd0;
        end else if (lat >= 1 && lat <= TIMEOUT) begin
            reqs = lat; err = 1'b0; owb = wb; ld_chk = 1'b1;
            ldres = ld ? data : 32'd0;
        end else begin
            reqs = TIMEOUT; err = 1'b1; owb = 1'b0; ld_chk = 1'b0; ldres = 32'd0;
        end
        exp_q.push_back({p, a, i, ld, call, owb, err});
    endtask

    // Issue one instruction, play the memory, check the resulting pulse.
    task automatic run_one(input string name, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] o, input logic [31:0] i,
                           input logic ld, input logic st, input logic call, input logic wb,
                           input int lat, input logic [31:0] data);
        int reqs, cyc, w;
        logic [31:0] ldres;
        bit ld_chk;
        logic is_store;
        logic [W-1:0] exp_b, act_b;
        is_store = st && !ld;
        model(p, a, i, ld, st, call, wb, lat, data, reqs, ldres, ld_chk);
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready_before_issue: got %b expected 1", name, in_ready);
        end
        in_valid = 1'b1; in_pc = p; in_aluResult = a; in_op2 = o; in_inst = i;
        in_isLd = ld; in_isSt = st; in_isCall = call; in_isWb = wb;
        mem_ready = ready_tied; mem_rdata = $urandom();
        step();
        in_valid = 1'b0; in_isLd = 1'b0; in_isSt = 1'b0;
        cyc = 0;
        while (mem_req === 1'b1 && cyc < 40) begin
            cyc++;
            total++;
            if ({mem_addr, mem_we, in_ready, out_valid} !== {a, is_store, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL %s req_cycle%0d: got addr=%h we=%b rdy=%b ov=%b expected addr=%h we=%b rdy=0 ov=0",
                         name, cyc, mem_addr, mem_we, in_ready, out_valid, a, is_store);
            end
            if (is_store) begin
                total++;
                if (mem_wdata !== o) begin
                    bad++;
                    $display("FAIL %s wdata: got %h expected %h", name, mem_wdata, o);
                end
            end
            mem_ready = (cyc == lat) ? 1'b1 : ready_tied;
            mem_rdata = (cyc == lat) ? data : $urandom();
            step();
            mem_ready = ready_tied;
        end
        total++;
        if (cyc != reqs) begin
            bad++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, cyc, reqs);
        end
        exp_b = exp_q.pop_front();
        act_b = {pc, aluResult, inst, isLd, isCall, isWb, mem_err};
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
        end
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL %s bundle: got %h expected %h", name, act_b, exp_b);
        end
        if (ld_chk) begin
            total++;
            if (ldResult !== ldres) begin
                bad++;
                $display("FAIL %s ldResult: got %h expected %h", name, ldResult, ldres);
            end
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready_at_pulse: got %b expected 1", name, in_ready);
        end
        step();
        total++;
        if ({out_valid, isWb, mem_err} !== 3'b000) begin
            bad++;
            $display("FAIL %s after_pulse: got ov/wb/err=%b expected 000", name, {out_valid, isWb, mem_err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h10; in_aluResult = 32'h40;
        in_op2 = 32'h5; in_inst = 32'h77; in_isLd = 1'b1; in_isSt = 1'b0;
        in_isCall = 1'b1; in_isWb = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0;
        step();
        step();
        total++;
        if ({out_valid, mem_req, mem_err, dbg_state} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, mem_req, mem_err, dbg_state});
        end
        total++;
        if ({pc, ldResult, aluResult, inst} !== 128'd0) begin
            bad++;
            $display("FAIL reset_bundle: got %h expected 0", {pc, ldResult, aluResult, inst});
        end
        total++;
        if ({isLd, isCall, isWb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 000", {isLd, isCall, isWb});
        end
        rst = 1'b0; in_valid = 1'b0; in_isLd = 1'b0; in_isCall = 1'b0; in_isWb = 1'b0;
        step();
        total++;
        if ({in_ready, out_valid, mem_req} !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: got rdy/ov/req=%b expected 100", {in_ready, out_valid, mem_req});
        end
    endtask

    task automatic test_alu_op();
        run_one("alu_op", 32'h100, 32'h2A, 32'h0, 32'h0ABC_0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_alu[6];
        logic [31:0] exp_pc[6];
        logic        exp_wb[6];
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                total++;
                if ({out_valid, pc, aluResult, isWb} !== {1'b1, exp_pc[k-1], exp_alu[k-1], exp_wb[k-1]}) begin
                    bad++;
                    $display("FAIL b2b_%0d: got ov=%b pc=%h alu=%h wb=%b expected ov=1 pc=%h alu=%h wb=%b",
                             k - 1, out_valid, pc, aluResult, isWb, exp_pc[k-1], exp_alu[k-1], exp_wb[k-1]);
                end
            end
            if (k < 6) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_%0d: got %b expected 1", k, in_ready);
                end
                exp_alu[k] = $urandom(); exp_pc[k] = $urandom(); exp_wb[k] = 1'($urandom_range(0, 1));
                in_valid = 1'b1; in_pc = exp_pc[k]; in_aluResult = exp_alu[k]; in_inst = $urandom();
                in_isLd = 1'b0; in_isSt = 1'b0; in_isCall = 1'b0; in_isWb = exp_wb[k];
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        total++;
        if ({out_valid, isWb} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_end: got ov/wb=%b expected 00", {out_valid, isWb});
        end
    endtask

    task automatic test_load_wait3();
        run_one("load_wait3", 32'h200, 32'h40, 32'h0, 32'h1111_0003, 1'b1, 1'b0, 1'b0, 1'b1, 3, 32'hDEADBEEF);
    endtask

    task automatic test_store_zero_wait();
        ready_tied = 1'b1;
        run_one("store_zero_wait", 32'h204, 32'h80, 32'h1234, 32'h2222_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'hCAFEF00D);
        ready_tied = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic test_misaligned();
        run_one("misaligned", 32'h208, 32'h42, 32'h0, 32'h3333_0005, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h5555AAAA);
    endtask

    task automatic test_timeout();
        run_one("timeout", 32'h20C, 32'h44, 32'h0, 32'h4444_0006, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'd0);
    endtask

    task automatic test_reset_mid_load();
        in_valid = 1'b1; in_pc = 32'h300; in_aluResult = 32'h40; in_op2 = 32'd0;
        in_inst = 32'h5555_0007; in_isLd = 1'b1; in_isSt = 1'b0; in_isCall = 1'b0; in_isWb = 1'b1;
        mem_ready = 1'b0;
        step();
        in_valid = 1'b0; in_isLd = 1'b0;
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL midreset_req1: got %b expected 1", mem_req);
        end
        step();
        rst = 1'b1;
        step();
        total++;
        if ({mem_req, out_valid, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL midreset_after: got req/ov/rdy=%b expected 001", {mem_req, out_valid, in_ready});
        end
        rst = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 32'hBADC0DE0;
        step();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({mem_req, out_valid, mem_err} !== 3'b000) begin
                bad++;
                $display("FAIL midreset_late_ready_%0d: got req/ov/err=%b expected 000", k, {mem_req, out_valid, mem_err});
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int sel;
        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            sel = $urandom_range(0, 3);
            run_one($sformatf("rand%0d", n), $urandom(), a, $urandom(), $urandom(),
                    (sel == 1 || sel == 3), (sel == 2 || sel == 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), $urandom());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_back_to_back();
        test_load_wait3();
        test_store_zero_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
